// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC sequencer driving the write side of program_counter.
// It issues one fetch handshake per PC value, then writes the next PC. The next
// PC is either the current PC plus INC or the branch target. Stall and halt
// requests are honoured between fetches.
//
// Ports:
//   CLK, RST_N    clock (rising edge), asynchronous active-low reset
//   pc_cur        current PC read back from program_counter
//   pc_next, W_PC value and one-cycle write strobe for program_counter (registered)
//   fetch_req     fetch request for pc_cur (registered); fetch_ack completes it
//   stall, halt   hold the PC update / stop permanently until reset
//   br_taken      select br_target as the next PC
//   br_target     branch target address
//   halted        high once halted (registered)
//   fetch_cnt     saturating count of accepted acks (only with PC_SEQ_PERF_CNT_EN)
//
// Optional feature macro: PC_SEQ_PERF_CNT_EN
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      INC          = 1,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] pc_cur,
    output logic [WIDTH-1:0] pc_next,
    output logic             W_PC,
    output logic             fetch_req,
    input  logic             fetch_ack,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             halt,
    output logic             halted
`ifdef PC_SEQ_PERF_CNT_EN
   ,output logic [15:0]      fetch_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_FETCH,
        ST_UPDATE,
        ST_WAIT,
        ST_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_next_d;
    logic             w_pc_d, fetch_req_d, halted_d;

    // Next-state and next-output logic. In LOAD and UPDATE the registered W_PC
    // marks the cycle in which the write is being presented.
    always_comb begin
        state_d     = state_q;
        pc_next_d   = pc_next;
        w_pc_d      = 1'b0;
        fetch_req_d = fetch_req;
        halted_d    = halted;
        case (state_q)
            ST_LOAD: begin
                if (!W_PC) begin
                    w_pc_d    = 1'b1;
                    pc_next_d = RESET_VECTOR;
                end else begin
                    state_d     = ST_FETCH;
                    fetch_req_d = 1'b1;
                end
            end
            ST_FETCH: begin
                fetch_req_d = 1'b1;
                if (fetch_ack) begin
                    state_d     = ST_UPDATE;
                    fetch_req_d = 1'b0;
                end
            end
            ST_UPDATE: begin
                if (W_PC) begin
                    state_d = ST_WAIT;
                end else if (halt) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else if (!stall) begin
                    pc_next_d = br_taken ? br_target : pc_cur + WIDTH'(INC);
                    w_pc_d    = 1'b1;
                end
            end
            ST_WAIT: begin
                state_d     = ST_FETCH;
                fetch_req_d = 1'b1;
            end
            ST_HALTED: begin
                halted_d    = 1'b1;
                fetch_req_d = 1'b0;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_LOAD;
            pc_next   <= RESET_VECTOR;
            W_PC      <= 1'b0;
            fetch_req <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_next   <= pc_next_d;
            W_PC      <= w_pc_d;
            fetch_req <= fetch_req_d;
            halted    <= halted_d;
        end
    end

`ifdef PC_SEQ_PERF_CNT_EN
    logic [15:0] fetch_cnt_d;

    // Saturating count of acks accepted in FETCH.
    always_comb begin
        fetch_cnt_d = fetch_cnt;
        if (state_q == ST_FETCH && fetch_ack && fetch_cnt != 16'hFFFF) begin
            fetch_cnt_d = fetch_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_cnt <= 16'd0;
        end else begin
            fetch_cnt <= fetch_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. It includes a simple program_counter
// register and a transaction-level expectation of the PC sequence.
module tb_pc_sequencer;

    localparam int unsigned W = 32;
    localparam logic [W-1:0] RV = '0;

    logic         CLK;
    logic         RST_N;
    logic [W-1:0] pc_cur;
    logic [W-1:0] pc_next;
    logic         W_PC;
    logic         fetch_req;
    logic         fetch_ack;
    logic         stall;
    logic         br_taken;
    logic [W-1:0] br_target;
    logic         halt;
    logic         halted;
`ifdef PC_SEQ_PERF_CNT_EN
    logic [15:0]  fetch_cnt;
`endif

    pc_sequencer #(.WIDTH(W), .INC(1), .RESET_VECTOR(RV)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .pc_cur    (pc_cur),
        .pc_next   (pc_next),
        .W_PC      (W_PC),
        .fetch_req (fetch_req),
        .fetch_ack (fetch_ack),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .halt      (halt),
        .halted    (halted)
`ifdef PC_SEQ_PERF_CNT_EN
       ,.fetch_cnt (fetch_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // program_counter stand-in: captures pc_next on a write strobe.
    logic [W-1:0] pc_reg;
    initial pc_reg = 32'hDEAD_BEEF;
    always @(posedge CLK) if (W_PC) pc_reg <= pc_next;
    assign pc_cur = pc_reg;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] exp_pc;   // value program_counter should hold after the last write
    int           exp_cnt;  // acks accepted in FETCH since reset

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Inputs that must be ignored in the current state.
    task automatic noise();
        stall     = 1'($urandom);
        halt      = 1'($urandom);
        br_taken  = 1'($urandom);
        br_target = $urandom;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef PC_SEQ_PERF_CNT_EN
        chk(tag, W'(fetch_cnt), W'(exp_cnt));
`else
        if (tag.len() == 0) exp_cnt = exp_cnt;
`endif
    endtask

    // Hold reset for two cycles, release, and check the LOAD write.
    task automatic do_reset();
        RST_N = 1'b0;
        fetch_ack = 1'b0; stall = 1'b0; halt = 1'b0; br_taken = 1'b0; br_target = '0;
        tick();
        tick();
        chk("rst_w_pc", W'(W_PC), 0);
        chk("rst_fetch_req", W'(fetch_req), 0);
        chk("rst_halted", W'(halted), 0);
        chk("rst_pc_next", pc_next, RV);
        exp_cnt = 0;
        chk_cnt("rst_fetch_cnt");
        RST_N = 1'b1;
        tick();
        chk("load_w_pc", W'(W_PC), 1);
        chk("load_pc_next", pc_next, RV);
        chk("load_fetch_req", W'(fetch_req), 0);
        exp_pc = RV;
        tick();
        chk("load_done_w_pc", W'(W_PC), 0);
        chk("fetch_req_rise", W'(fetch_req), 1);
        chk("pc_cur_after_load", pc_cur, exp_pc);
    endtask

    // FETCH: hold ack low for dly cycles, then ack.
    task automatic do_fetch(input int dly);
        for (int i = 0; i < dly; i++) begin
            noise();
            fetch_ack = 1'b0;
            tick();
            chk("fetch_hold_req", W'(fetch_req), 1);
            chk("fetch_hold_w_pc", W'(W_PC), 0);
        end
        noise();
        fetch_ack = 1'b1;
        tick();
        exp_cnt++;
        chk("fetch_req_drop", W'(fetch_req), 0);
        chk("fetch_w_pc", W'(W_PC), 0);
        fetch_ack = 1'b0;
    endtask

    // UPDATE with nstall stalled cycles, then the write, WAIT, back to FETCH.
    task automatic do_update(input int nstall, input logic br, input logic [W-1:0] tgt);
        halt = 1'b0;
        for (int i = 0; i < nstall; i++) begin
            stall     = 1'b1;
            br_taken  = 1'($urandom);
            br_target = $urandom;
            fetch_ack = 1'($urandom);
            tick();
            chk("stall_w_pc", W'(W_PC), 0);
            chk("stall_fetch_req", W'(fetch_req), 0);
        end
        stall     = 1'b0;
        br_taken  = br;
        br_target = tgt;
        fetch_ack = 1'($urandom);
        tick();
        exp_pc = br ? tgt : exp_pc + 32'd1;
        chk("write_w_pc", W'(W_PC), 1);
        chk("write_pc_next", pc_next, exp_pc);
        stall = 1'b0; halt = 1'b0; br_taken = 1'($urandom); br_target = $urandom;
        fetch_ack = 1'($urandom);
        tick();
        chk("wait_w_pc", W'(W_PC), 0);
        chk("wait_fetch_req", W'(fetch_req), 0);
        chk("pc_cur_captured", pc_cur, exp_pc);
        fetch_ack = 1'($urandom);
        tick();
        chk("refetch_req", W'(fetch_req), 1);
        chk("refetch_w_pc", W'(W_PC), 0);
        chk("pc_next_hold", pc_next, exp_pc);
        fetch_ack = 1'b0;
        chk_cnt("fetch_cnt");
    endtask

    initial begin
        RST_N = 1'b0;
        fetch_ack = 1'b0; stall = 1'b0; halt = 1'b0; br_taken = 1'b0; br_target = '0;
        exp_pc = RV;
        exp_cnt = 0;

        // Sequential pulses 1, 2, 3 with ack held high.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_fetch(0);
            do_update(0, 1'b0, '0);
        end

        // Branch to 0x100 then sequential 0x101.
        do_fetch(0);
        do_update(0, 1'b1, 32'h0000_0100);
        do_fetch(1);
        do_update(0, 1'b0, '0);

        // Branch to all-ones then wrap to zero.
        do_fetch(0);
        do_update(0, 1'b1, 32'hFFFF_FFFF);
        do_fetch(0);
        do_update(0, 1'b0, '0);

        // Three stalled UPDATE cycles.
        do_fetch(2);
        do_update(3, 1'b0, '0);

        // Randomized fetch latency, stalls and branches.
        for (int i = 0; i < 25; i++) begin
            do_fetch(int'($urandom_range(0, 3)));
            do_update(int'($urandom_range(0, 3)), (($urandom % 3) == 0), $urandom);
        end

        // halt wins over stall; HALTED is sticky.
        do_fetch(0);
        halt = 1'b1; stall = 1'b1; br_taken = 1'b0;
        tick();
        chk("halt_halted", W'(halted), 1);
        chk("halt_w_pc", W'(W_PC), 0);
        chk("halt_fetch_req", W'(fetch_req), 0);
        for (int i = 0; i < 8; i++) begin
            noise();
            fetch_ack = 1'($urandom);
            tick();
            chk("halted_sticky", W'(halted), 1);
            chk("halted_w_pc", W'(W_PC), 0);
            chk("halted_fetch_req", W'(fetch_req), 0);
        end
        fetch_ack = 1'b0;
        chk_cnt("halted_fetch_cnt");

        // Reset from HALTED, then asynchronous reset mid-FETCH.
        do_reset();
        do_fetch(0);
        do_update(0, 1'b0, '0);
        #3;
        RST_N = 1'b0;
        #1;
        chk("async_rst_fetch_req", W'(fetch_req), 0);
        chk("async_rst_w_pc", W'(W_PC), 0);
        chk("async_rst_pc_next", pc_next, RV);
        do_reset();
        do_fetch(0);
        do_update(0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC sequencer that drives the write side of `program_counter`. It owns that register's `in` and `W_PC` inputs and reads its `out` back. It issues one instruction-fetch handshake per PC value, then computes and writes the next PC: sequential increment or taken-branch target. Stall and halt requests are honoured between fetches.

## Interface
- `WIDTH`, 32, PC width in bits
- `INC`, 1, sequential PC increment
- `RESET_VECTOR`, 0, first PC written after reset
- `CLK`  in  1  clock, rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `pc_cur`  in  WIDTH  current PC, fed back from `program_counter` out
- `pc_next`  out  WIDTH  value presented to `program_counter` in; registered
- `W_PC`  out  1  write strobe to `program_counter`; registered, one-cycle pulse
- `fetch_req`  out  1  fetch request for address `pc_cur`; registered
- `fetch_ack`  in  1  fetch completion from instruction memory
- `stall`  in  1  hold PC update
- `br_taken`  in  1  select branch target for the next PC
- `br_target`  in  WIDTH  branch target address
- `halt`  in  1  stop sequencing permanently until reset
- `halted`  out  1  high in HALTED state
- `fetch_cnt`  out  16  completed fetch count; only present with `PC_SEQ_PERF_CNT_EN`

## Operation
- **Reset values** (while `RST_N`=0): state LOAD, `pc_next`=`RESET_VECTOR`, `W_PC`=0, `fetch_req`=0, `halted`=0, `fetch_cnt`=0.
- **LOAD**
  - Drives `W_PC`=1 with `pc_next`=`RESET_VECTOR` for exactly one cycle.
  - Next state: FETCH.
- **FETCH**
  - `fetch_req`=1 and held until `fetch_ack` is sampled high.
  - On ack, go to UPDATE. `fetch_req` drops the cycle after the ack edge.
  - `stall`, `halt` and `br_*` are ignored in FETCH.
- **UPDATE**, checked in priority order each cycle:
  - `halt`=1: go to HALTED; no write.
  - Else `stall`=1: stay in UPDATE with `W_PC`=0.
  - Else: write `pc_next` = `br_taken` ? `br_target` : `pc_cur` + `INC` (mod 2^WIDTH), with `W_PC`=1 for one cycle. Go to WAIT.
- **WAIT**
  - One cycle with `W_PC`=0 while `program_counter` updates.
  - Next state: FETCH.
- **HALTED**
  - `halted`=1; `W_PC`=0 and `fetch_req`=0.
  - Leaves only via reset.
- **Input and output rules**
  - `fetch_ack` outside FETCH is ignored.
  - `br_target` is used unmodified; alignment is the producer's concern.
  - `pc_next` holds its last written value when `W_PC`=0.

## Timing
- Reset deassertion edge N: LOAD, `W_PC`=1. Edge N+1: `program_counter` captures `RESET_VECTOR`; state is FETCH. `fetch_req`=1 from after edge N+1.
- Ack sampled at edge A puts the block in UPDATE with no stall. Edge A+1 presents the new `pc_next` with `W_PC`=1. At edge A+2, `program_counter` captures it and the block enters WAIT. `fetch_req` rises again after edge A+3.
- Minimum spacing between consecutive `W_PC` pulses is 4 cycles (UPDATE, WAIT, FETCH with same-cycle ack, UPDATE). A stall adds one cycle per stalled cycle.
- Reset mid-operation (any state) forces all outputs to their reset values asynchronously. No partial write survives.

## Configuration
- `PC_SEQ_PERF_CNT_EN` defined: `fetch_cnt` port exists.
  - Increments by 1 on each accepted `fetch_ack` in FETCH.
  - Saturates at 16'hFFFF and clears only on reset.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release, ack held high -> `W_PC` pulses with `pc_next`=0. Subsequent pulses carry 1, 2, 3, spaced 4 cycles apart.
- `br_taken`=1 with `br_target`=32'h100 during UPDATE -> next pulse carries 32'h100, then 32'h101.
- Branch to 32'hFFFFFFFF, then sequential -> next `pc_next`=32'h0 (wrap).
- `stall`=1 for 3 UPDATE cycles -> `W_PC` stays low for exactly 3 extra cycles, then pulses with `pc_cur`+1.
- `halt` and `stall` both high in UPDATE -> `halted`=1, no further `W_PC` or `fetch_req`. Then reset mid-FETCH -> `fetch_req`=0 immediately and LOAD re-writes 0.
- With `PC_SEQ_PERF_CNT_EN` and 5 acks -> `fetch_cnt`=5. Ack pulses outside FETCH leave the count unchanged.
